ahb_tgen_master: RTL and testbench
==================================

AHB_TGEN_MASTER -- requirements
Module: ahb_tgen_master

Interface
REQ-001 Parameter HADDR_WIDTH, 32, address bus width.
REQ-002 Parameter DATA_WIDTH, 32, data bus width; only 32 supported for hsize=WORD.
REQ-003 Parameter DATA_SEED, 32'h0000_0000, first write-data value after start.
REQ-004 Ports, one per line (clock and reset first):
  hclk  in  1  clock; single clock domain.
  hresetn  in  1  reset; asynchronous assert, active-low.
  start  in  1  one-cycle request; sampled only in IDLE.
  cfg_write  in  1  1 = write bursts, 0 = read bursts.
  cfg_wrap  in  1  1 = WRAP bursts, 0 = INCR bursts.
  cfg_beats  in  2  0 = 4 beats, 1 = 8 beats, 2 or 3 = 16 beats.
  cfg_addr  in  HADDR_WIDTH  start byte address.
  cfg_nburst  in  8  number of bursts; 0 = no transfer.
  hready  in  1  transfer-done input from interconnect.
  hresp  in  1  error response input from interconnect.
  hrdata  in  DATA_WIDTH  read data.
  haddr  out  HADDR_WIDTH  AHB address.
  hburst  out  3  AHB burst type.
  htrans  out  2  AHB transfer type.
  hsize  out  3  constant 3'b010 (WORD).
  hwrite  out  1  AHB direction.
  hwdata  out  DATA_WIDTH  AHB write data.
  hprot  out  4  constant 4'b0011.
  hmasterlock  out  1  constant 0.
  busy  out  1  sequence in progress.
  done  out  1  one-cycle completion pulse.
  err  out  1  sticky error flag.
  rd_sum  out  DATA_WIDTH  read checksum.
REQ-005 All cfg_* inputs SHALL be captured on the cycle start is accepted; later changes SHALL have no effect until the next start.

Function
REQ-006 FSM states SHALL be IDLE, ADDR, LAST, ERR and DONE.
REQ-007 IDLE + start + cfg_nburst!=0: go to ADDR; the next cycle SHALL drive htrans=NONSEQ with the first burst address.
REQ-008 IDLE + start + cfg_nburst==0: go to DONE; no bus transfer SHALL be issued.
REQ-009 The address phase (haddr, htrans, hburst, hwrite) SHALL advance only on a cycle with hready=1; while hready=0 it SHALL be held stable.
REQ-010 Beat 0 of each burst SHALL be NONSEQ and later beats SEQ.
REQ-011 Bursts SHALL be issued back to back, with no IDLE or BUSY between them.
REQ-012 hburst encoding SHALL be: INCR4=3, WRAP4=2, INCR8=5, WRAP8=4, INCR16=7, WRAP16=6.
REQ-013 Burst byte size SHALL be S = beats*4.
REQ-014 INCR: burst start address SHALL be cfg_addr aligned down to S, so no burst crosses 1KB.
REQ-015 WRAP: burst start address SHALL be cfg_addr with bits [1:0] cleared.
REQ-016 Within a WRAP burst, haddr SHALL increment by 4 and wrap at the S-aligned boundary.
REQ-017 The start address of burst n+1 SHALL be the start of burst n plus S, modulo 2^HADDR_WIDTH.
REQ-018 Write data for global beat k (k from 0) SHALL be DATA_SEED+k, modulo 2^DATA_WIDTH.
REQ-019 hwdata SHALL be driven during that beat's data phase and held while hready=0.
REQ-020 On reads, rd_sum SHALL add hrdata modulo 2^DATA_WIDTH at each data phase completing with hready=1 and hresp=0.
REQ-021 rd_sum SHALL be cleared to 0 when start is accepted.
REQ-022 After the final address phase is accepted: go to LAST with htrans=IDLE; when that data phase completes, go to DONE.
REQ-023 DONE SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-024 busy SHALL be 1 from the cycle after start is accepted through the done cycle inclusive.
REQ-025 Error, first cycle of response (hresp=1, hready=0): the next cycle SHALL drive htrans=IDLE, set err=1 and enter ERR; remaining beats are cancelled.
REQ-026 ERR + hready=1: go to DONE.
REQ-027 If hresp=1 and the last data phase complete together, err SHALL still be set.
REQ-028 start SHALL be ignored whenever the state is not IDLE.
REQ-029 err SHALL stay set until the next accepted start, which clears it.
REQ-030 beat and burst counters SHALL wrap only by the reload from cfg at each new burst or start.

Reset
REQ-031 On hresetn low, asynchronously and including mid-burst, all of the following SHALL apply:
  state = IDLE, htrans = 0, haddr = 0, hburst = 0, hwrite = 0, hwdata = 0;
  busy = 0, done = 0, err = 0, rd_sum = 0;
  all counters = 0.
REQ-032 After hresetn deasserts, the block SHALL wait for a new start before any transfer.

Verification
REQ-033 Write INCR4, cfg_addr=0x4003_0004, nburst=2, hready=1:
  -> haddr 0x40030000 to 0x4003001C, htrans NONSEQ,SEQ,SEQ,SEQ,NONSEQ,SEQ,SEQ,SEQ;
  -> hwdata 0..7; done pulses 10 cycles after start.
REQ-034 Read WRAP8, cfg_addr=0x18, nburst=1, hrdata=1 per beat:
  -> haddr 0x18,0x1C,0x00 .. 0x14;
  -> hburst=4; rd_sum=8.
REQ-035 INCR16 with hready low for 3 cycles on beat 5:
  -> haddr, htrans and hwdata held stable;
  -> sequence completes with 16 beats and no lost or duplicated beat.
REQ-036 Two-cycle error on beat 2 of 4:
  -> htrans=IDLE on the cycle after hresp=1, hready=0;
  -> err=1 and done pulse; next start clears err.
REQ-037 nburst=0 -> done the cycle after start, htrans stays IDLE.
REQ-038 Start during busy -> ignored.
REQ-039 hresetn low mid-burst -> all outputs 0 at once.

Source files
------------

// File: rtl/ahb_tgen_master.sv
// AHB-Lite traffic generator: issues N back-to-back INCR/WRAP 4/8/16 bursts, checksums reads.
// Latency: first NONSEQ the cycle after start; done pulses one cycle after the last data phase.
// Backpressure: hready=0 freezes the address and data phases; an ERROR response cancels the remaining beats.
module ahb_tgen_master #(
    parameter int                    HADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] DATA_SEED   = '0
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic                   start,
    input  logic                   cfg_write,
    input  logic                   cfg_wrap,
    input  logic [1:0]             cfg_beats,
    input  logic [HADDR_WIDTH-1:0] cfg_addr,
    input  logic [7:0]             cfg_nburst,
    input  logic                   hready,
    input  logic                   hresp,
    input  logic [DATA_WIDTH-1:0]  hrdata,
    output logic [HADDR_WIDTH-1:0] haddr,
    output logic [2:0]             hburst,
    output logic [1:0]             htrans,
    output logic [2:0]             hsize,
    output logic                   hwrite,
    output logic [DATA_WIDTH-1:0]  hwdata,
    output logic [3:0]             hprot,
    output logic                   hmasterlock,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [DATA_WIDTH-1:0]  rd_sum
);

    typedef enum logic [2:0] {IDLE, ADDR, LAST, ERR, DONE} state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    state_t                 state, state_nxt;
    logic [HADDR_WIDTH-1:0] base_q;
    logic [3:0]             beats_m1_q;
    logic [3:0]             beat_q;
    logic [7:0]             burst_left_q;
    logic [DATA_WIDTH-1:0]  wdat_q;
    logic                   dph_vld_q;

    logic [1:0]             beats_sel;
    logic [3:0]             beats_m1_in;
    logic [HADDR_WIDTH-1:0] mask_in, mask_q, start_base, burst_size;
    logic                   start_acc, addr_acc, err_first, last_beat, last_burst;

    // beats_sel is 1/2/3 for 4/8/16 beats; it doubles as the upper hburst bits
    assign beats_sel   = (cfg_beats == 2'd0) ? 2'd1 : (cfg_beats == 2'd1) ? 2'd2 : 2'd3;
    assign beats_m1_in = (beats_sel == 2'd1) ? 4'd3 : (beats_sel == 2'd2) ? 4'd7 : 4'd15;
    assign mask_in     = {{(HADDR_WIDTH-6){1'b0}}, beats_m1_in, 2'b11};
    assign mask_q      = {{(HADDR_WIDTH-6){1'b0}}, beats_m1_q, 2'b11};
    assign burst_size  = mask_q + {{(HADDR_WIDTH-1){1'b0}}, 1'b1};
    assign start_base  = cfg_wrap ? {cfg_addr[HADDR_WIDTH-1:2], 2'b00} : (cfg_addr & ~mask_in);

    assign start_acc   = (state == IDLE) && start;
    assign addr_acc    = (state == ADDR) && hready;
    assign err_first   = dph_vld_q && hresp && !hready;
    assign last_beat   = (beat_q == beats_m1_q);
    assign last_burst  = (burst_left_q == 8'd1);

    // INCR bases are already S-aligned, so the wrapping form yields a plain increment for them too
    function automatic logic [HADDR_WIDTH-1:0] beat_addr(input logic [HADDR_WIDTH-1:0] base,
                                                         input logic [3:0]             beat,
                                                         input logic [HADDR_WIDTH-1:0] mask);
        logic [HADDR_WIDTH-1:0] off;
        off = {{(HADDR_WIDTH-6){1'b0}}, beat, 2'b00};
        return (base & ~mask) | ((base + off) & mask);
    endfunction

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = (cfg_nburst == 8'd0) ? DONE : ADDR;
            ADDR: begin
                if (err_first)                              state_nxt = ERR;
                else if (hready && last_beat && last_burst) state_nxt = LAST;
            end
            LAST: begin
                if (err_first)   state_nxt = ERR;
                else if (hready) state_nxt = DONE;
            end
            ERR:  if (hready) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            haddr        <= '0;
            htrans       <= HT_IDLE;
            hburst       <= 3'd0;
            hwrite       <= 1'b0;
            hwdata       <= '0;
            base_q       <= '0;
            beats_m1_q   <= 4'd0;
            beat_q       <= 4'd0;
            burst_left_q <= 8'd0;
            wdat_q       <= '0;
            dph_vld_q    <= 1'b0;
        end else begin
            if (start_acc) begin
                beats_m1_q   <= beats_m1_in;
                base_q       <= start_base;
                beat_q       <= 4'd0;
                burst_left_q <= cfg_nburst;
                wdat_q       <= DATA_SEED;
                hburst       <= {beats_sel, ~cfg_wrap};
                hwrite       <= cfg_write;
                if (cfg_nburst != 8'd0) begin
                    haddr  <= start_base;
                    htrans <= HT_NONSEQ;
                end
            end else if (err_first) begin
                htrans <= HT_IDLE;
            end else if (addr_acc) begin
                hwdata <= wdat_q;
                wdat_q <= wdat_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
                if (last_beat && last_burst) begin
                    htrans <= HT_IDLE;
                end else if (last_beat) begin
                    base_q       <= base_q + burst_size;
                    haddr        <= base_q + burst_size;
                    beat_q       <= 4'd0;
                    burst_left_q <= burst_left_q - 8'd1;
                    htrans       <= HT_NONSEQ;
                end else begin
                    beat_q <= beat_q + 4'd1;
                    haddr  <= beat_addr(base_q, beat_q + 4'd1, mask_q);
                    htrans <= HT_SEQ;
                end
            end
            if (hready) dph_vld_q <= addr_acc;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            err    <= 1'b0;
            rd_sum <= '0;
        end else if (start_acc) begin
            err    <= 1'b0;
            rd_sum <= '0;
        end else begin
            // an ERROR seen on either response cycle sets err, even on the final beat
            if (dph_vld_q && hresp) err <= 1'b1;
            if (dph_vld_q && hready && !hresp && !hwrite) rd_sum <= rd_sum + hrdata;
        end
    end

    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign hsize       = 3'b010;
    assign hprot       = 4'b0011;
    assign hmasterlock = 1'b0;

endmodule

// File: tb/tb_ahb_tgen_master.sv
`timescale 1ns/1ps
module tb_ahb_tgen_master;
    localparam logic [31:0] SEED = 32'h0;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        start = 1'b0, cfg_write = 1'b0, cfg_wrap = 1'b0;
    logic [1:0]  cfg_beats = 2'd0;
    logic [31:0] cfg_addr = 32'd0;
    logic [7:0]  cfg_nburst = 8'd0;
    logic        hready = 1'b1, hresp = 1'b0;
    logic [31:0] hrdata = 32'd0;
    logic [31:0] haddr, hwdata, rd_sum;
    logic [2:0]  hburst, hsize;
    logic [1:0]  htrans;
    logic [3:0]  hprot;
    logic        hwrite, hmasterlock, busy, done, err;

    ahb_tgen_master #(.HADDR_WIDTH(32), .DATA_WIDTH(32), .DATA_SEED(SEED)) dut (
        .hclk(hclk), .hresetn(hresetn), .start(start), .cfg_write(cfg_write), .cfg_wrap(cfg_wrap),
        .cfg_beats(cfg_beats), .cfg_addr(cfg_addr), .cfg_nburst(cfg_nburst), .hready(hready),
        .hresp(hresp), .hrdata(hrdata), .haddr(haddr), .hburst(hburst), .htrans(htrans),
        .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hprot(hprot), .hmasterlock(hmasterlock),
        .busy(busy), .done(done), .err(err), .rd_sum(rd_sum)
    );

    always #5 hclk = ~hclk;

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] q_addr[$];
    logic [1:0]  q_trans[$];
    logic [31:0] acc_addr[$];
    logic [1:0]  acc_trans[$];
    logic [2:0]  acc_burst[$];
    logic        m_busy = 0, m_done_exp = 0, m_err = 0, m_dph = 0, m_write = 0;
    logic [2:0]  m_burst = 0;
    logic [31:0] m_sum = 0;
    int          m_k = 0, k_issue = 0;
    logic        prev_hold = 0;
    logic [31:0] prev_addr = 0;
    logic [1:0]  prev_trans = 0;

    task automatic load_model();
        int beats;
        logic [31:0] s, base, win, off;
        beats = (cfg_beats == 2'd0) ? 4 : (cfg_beats == 2'd1) ? 8 : 16;
        s     = 32'(beats * 4);
        base  = cfg_wrap ? (cfg_addr & ~32'd3) : (cfg_addr - (cfg_addr % s));
        q_addr.delete(); q_trans.delete();
        for (int b = 0; b < int'(cfg_nburst); b++) begin
            win = base - (base % s);
            off = base % s;
            for (int j = 0; j < beats; j++) begin
                q_addr.push_back(cfg_wrap ? win + ((off + 32'(4*j)) % s) : base + 32'(4*j));
                q_trans.push_back(j == 0 ? 2'b10 : 2'b11);
            end
            base = base + s;
        end
        case (beats)
            4:       m_burst = cfg_wrap ? 3'd2 : 3'd3;
            8:       m_burst = cfg_wrap ? 3'd4 : 3'd5;
            default: m_burst = cfg_wrap ? 3'd6 : 3'd7;
        endcase
    endtask

    always @(negedge hclk) begin : cmp
        logic b, acc, done_next;
        int acc_k;
        if (!hresetn) begin
            m_busy = 0; m_done_exp = 0; m_err = 0; m_dph = 0; m_sum = 0; prev_hold = 0;
            q_addr.delete(); q_trans.delete();
        end else begin
            b = m_busy; acc = 0; acc_k = 0; done_next = 0;
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done_exp));
            chk("err", 64'(err), 64'(m_err));
            chk("rd_sum", 64'(rd_sum), 64'(m_sum));
            chk("hsize", 64'(hsize), 64'd2);
            chk("hprot", 64'(hprot), 64'd3);
            chk("hmasterlock", 64'(hmasterlock), 64'd0);
            if (prev_hold) begin
                chk("hold_haddr", 64'(haddr), 64'(prev_addr));
                chk("hold_htrans", 64'(htrans), 64'(prev_trans));
            end
            if (q_addr.size() == 0) begin
                chk("htrans_idle", 64'(htrans), 64'd0);
            end else begin
                chk("haddr", 64'(haddr), 64'(q_addr[0]));
                chk("htrans", 64'(htrans), 64'(q_trans[0]));
                chk("hburst", 64'(hburst), 64'(m_burst));
                chk("hwrite", 64'(hwrite), 64'(m_write));
                if (hready) begin
                    acc = 1; acc_k = k_issue; k_issue++;
                    acc_addr.push_back(haddr); acc_trans.push_back(htrans); acc_burst.push_back(hburst);
                    void'(q_addr.pop_front()); void'(q_trans.pop_front());
                end
            end
            prev_hold = !hready && !hresp && (htrans != 2'b00);
            prev_addr = haddr; prev_trans = htrans;
            if (m_dph) begin
                if (m_write) chk("hwdata", 64'(hwdata), 64'(SEED + 32'(m_k)));
                if (hready && !hresp && !m_write) m_sum = m_sum + hrdata;
                if (hresp) m_err = 1;
                if (hresp && !hready) begin q_addr.delete(); q_trans.delete(); end
                if (hready && !acc && q_addr.size() == 0) done_next = 1;
            end
            if (hready) begin m_dph = acc; m_k = acc_k; end
            if (m_done_exp) m_busy = 0;
            m_done_exp = done_next;
            if (start && !b) begin
                m_busy = 1; m_err = 0; m_sum = 0; m_write = cfg_write; k_issue = 0;
                acc_addr.delete(); acc_trans.delete(); acc_burst.delete();
                load_model();
                if (cfg_nburst == 8'd0) m_done_exp = 1;
            end
        end
    end

    // ---------------- slave / stimulus ----------------
    logic eseq = 0, inj_en = 0, inj_done = 0, rnd_stall = 0, fix_rdata = 0, mid_start = 0, scramble = 0;
    int   inj_k = 0, stall_k = -1, stall_left = 0;

    task automatic drive_slave();
        hresp = 1'b0;
        if (eseq) begin
            hresp = 1'b1; hready = 1'b1; eseq = 0;
        end else if (m_dph && inj_en && !inj_done && m_k == inj_k) begin
            hresp = 1'b1; hready = 1'b0; eseq = 1; inj_done = 1;
        end else if (m_dph && m_k == stall_k && stall_left > 0) begin
            hready = 1'b0; stall_left--;
        end else begin
            hready = rnd_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        hrdata = fix_rdata ? 32'd1 : $urandom();
    endtask

    task automatic run_seq(input logic w, input logic wr, input logic [1:0] bt,
                           input logic [31:0] a, input logic [7:0] nb, output int lat);
        @(posedge hclk); #1;
        cfg_write = w; cfg_wrap = wr; cfg_beats = bt; cfg_addr = a; cfg_nburst = nb;
        start = 1'b1; inj_done = 0;
        drive_slave();
        lat = -1;
        for (int n = 1; n <= 3000; n++) begin
            @(posedge hclk); #1;
            start = mid_start && (n == 3);
            if (scramble) begin
                cfg_write = 1'($urandom_range(0, 1)); cfg_wrap = 1'($urandom_range(0, 1));
                cfg_beats = 2'($urandom_range(0, 3)); cfg_addr = $urandom();
                cfg_nburst = 8'($urandom_range(0, 255));
            end
            drive_slave();
            @(negedge hclk);
            if (done === 1'b1) begin lat = n; break; end
        end
        start = 1'b0;
        checks++;
        if (lat < 0) begin
            failures++;
            $display("FAIL seq_timeout: got no done expected done within 3000 cycles at %0t", $time);
        end
    endtask

    initial begin #900_000; $display("FAIL watchdog: got hang expected finish"); $fatal(1, "watchdog"); end

    initial begin
        int lat;
        repeat (3) @(posedge hclk);
        #1 hresetn = 1'b1;
        @(negedge hclk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_htrans", 64'(htrans), 64'd0);
        chk("rst_rd_sum", 64'(rd_sum), 64'd0);

        // write INCR4 x2 from an unaligned address
        run_seq(1, 0, 2'd0, 32'h4003_0004, 8'd2, lat);
        chk("t1_latency", 64'(lat), 64'd10);
        chk("t1_nbeats", 64'(acc_addr.size()), 64'd8);
        chk("t1_addr0", 64'(acc_addr[0]), 64'h4003_0000);
        chk("t1_addr7", 64'(acc_addr[7]), 64'h4003_001C);
        chk("t1_trans4", 64'(acc_trans[4]), 64'd2);
        chk("t1_trans1", 64'(acc_trans[1]), 64'd3);
        chk("t1_hwdata_last", 64'(hwdata), 64'd7);

        // read WRAP8 with hrdata=1
        fix_rdata = 1;
        run_seq(0, 1, 2'd1, 32'h0000_0018, 8'd1, lat);
        fix_rdata = 0;
        chk("t2_addr0", 64'(acc_addr[0]), 64'h18);
        chk("t2_addr1", 64'(acc_addr[1]), 64'h1C);
        chk("t2_addr2", 64'(acc_addr[2]), 64'h00);
        chk("t2_addr7", 64'(acc_addr[7]), 64'h14);
        chk("t2_hburst", 64'(acc_burst[0]), 64'd4);
        chk("t2_rd_sum", 64'(rd_sum), 64'd8);

        // INCR16 with a 3-cycle stall on beat 5
        stall_k = 5; stall_left = 3;
        run_seq(1, 0, 2'd2, 32'h0000_0100, 8'd1, lat);
        stall_k = -1;
        chk("t3_latency", 64'(lat), 64'd21);
        chk("t3_nbeats", 64'(acc_addr.size()), 64'd16);
        chk("t3_addr15", 64'(acc_addr[15]), 64'h13C);

        // two-cycle error on beat 2 of 4
        inj_en = 1; inj_k = 2;
        run_seq(1, 0, 2'd0, 32'h0000_0200, 8'd1, lat);
        inj_en = 0;
        chk("t4_latency", 64'(lat), 64'd6);
        chk("t4_nbeats", 64'(acc_addr.size()), 64'd3);
        chk("t4_err", 64'(err), 64'd1);

        // nburst=0: done the cycle after start, and the start clears err
        run_seq(0, 0, 2'd0, 32'h0000_0300, 8'd0, lat);
        chk("t5_latency", 64'(lat), 64'd1);
        chk("t5_nbeats", 64'(acc_addr.size()), 64'd0);
        chk("t5_err_cleared", 64'(err), 64'd0);

        // start while busy, cfg changing under a running sequence
        mid_start = 1; scramble = 1;
        run_seq(1, 0, 2'd1, 32'h0000_1000, 8'd2, lat);
        mid_start = 0; scramble = 0;
        chk("t6_latency", 64'(lat), 64'd18);
        chk("t6_nbeats", 64'(acc_addr.size()), 64'd16);

        // asynchronous reset mid-burst
        @(posedge hclk); #1;
        cfg_write = 1; cfg_wrap = 0; cfg_beats = 2'd2; cfg_addr = 32'h0000_3000; cfg_nburst = 8'd2;
        start = 1'b1; drive_slave();
        repeat (6) begin @(posedge hclk); #1; start = 1'b0; drive_slave(); end
        @(posedge hclk); #3;
        chk("t7_busy_before", 64'(busy), 64'd1);
        hresetn = 1'b0; #1;
        chk("t7_haddr", 64'(haddr), 64'd0);
        chk("t7_htrans", 64'(htrans), 64'd0);
        chk("t7_hburst", 64'(hburst), 64'd0);
        chk("t7_hwrite", 64'(hwrite), 64'd0);
        chk("t7_hwdata", 64'(hwdata), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_done", 64'(done), 64'd0);
        chk("t7_err", 64'(err), 64'd0);
        chk("t7_rd_sum", 64'(rd_sum), 64'd0);
        eseq = 0;
        @(posedge hclk); #1 hresetn = 1'b1;
        repeat (5) begin @(posedge hclk); #1; drive_slave(); end

        // randomized sequences
        rnd_stall = 1; scramble = 1;
        for (int i = 0; i < 40; i++) begin
            inj_en    = ($urandom_range(0, 4) == 0);
            inj_k     = int'($urandom_range(0, 15));
            mid_start = 1'($urandom_range(0, 1));
            run_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    $urandom(), 8'($urandom_range(0, 3)), lat);
        end
        rnd_stall = 0; scramble = 0; inj_en = 0; mid_start = 0;
        repeat (3) @(posedge hclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
